mispredict_recovery_ctrl: RTL
=============================

# mispredict_recovery_ctrl

Sequences branch-mispredict recovery after retire raises its single consolidated mispredict pulse. It flushes the speculative back end, then copies the architectural map table into the rename map table a few entries per cycle, then rebuilds the freelist and waits for in-flight functional units to drain. Finally it issues one fetch redirect. It sits between the retire stage and the rename/ROB/freelist/fetch blocks, and holds the front end and retire stalled for the whole sequence.

## Interface
- N, default `N: retire width; used only for the debug count width check.
- ARCH_COUNT, default `ARCH_REG_SZ (32): architectural registers to copy; must be a multiple of COPY_W.
- COPY_W, default 4: map entries copied per RESTORE cycle.
- DRAIN_MAX, default 15: maximum DRAIN cycles before forced exit.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- mispredict  in  1  from retire; one-cycle pulse.
- rob_mispred_idx  in  ROB_IDX  ROB index of the mispredicted branch; latched with mispredict.
- redirect_target  in  ADDR  correct next PC from retire; latched with mispredict.
- fu_busy  in  1  OR of all FU/CDB in-flight valids.
- flush_o  out  1  one-cycle flush of ROB younger than the latched index, RS, and FU pipelines.
- flush_idx_o  out  ROB_IDX  latched rob_mispred_idx; valid while flush_o=1.
- map_copy_en  out  1  rename map overwrites entries [base, base+COPY_W-1] from the arch map.
- map_copy_base  out  $clog2(ARCH_COUNT)  first arch register of the current group.
- freelist_restore  out  1  one-cycle pulse; freelist rebuilds as the complement of the arch map.
- stall_o  out  1  holds fetch, dispatch and retire.
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  ADDR  latched target; valid with redirect_valid.
- drain_timeout_dbg  out  1  sticky; set when DRAIN exits on DRAIN_MAX.
- recover_count_dbg  out  16  completed recoveries; wraps at 2^16.

## Operation
- States: IDLE, FLUSH, RESTORE, DRAIN, REDIRECT. State is 3-bit encoded and registered.
- IDLE: when mispredict=1, latch rob_mispred_idx and redirect_target, then go to FLUSH.
- FLUSH (1 cycle): flush_o=1 and flush_idx_o=latched index. Next state is RESTORE with copy_ctr=0.
- RESTORE (ARCH_COUNT/COPY_W cycles): map_copy_en=1 and map_copy_base=copy_ctr*COPY_W. copy_ctr increments each cycle.
  - On the last group, freelist_restore=1 and the next state is DRAIN with drain_ctr=0.
- DRAIN (≥1 cycle):
  - If fu_busy=0, go to REDIRECT.
  - Otherwise drain_ctr increments. When drain_ctr reaches DRAIN_MAX-1 with fu_busy still 1, set drain_timeout_dbg and go to REDIRECT.
- REDIRECT (1 cycle): redirect_valid=1 and redirect_pc=latched target. recover_count_dbg increments. Next state is IDLE.
- stall_o = (state != IDLE). It is decoded from registered state only, with no combinational path from mispredict.
- A mispredict pulse arriving in any state other than IDLE is ignored, and the latched values are unchanged. Retire is stalled, so such a pulse is a protocol error.
- map_copy_base arithmetic is unsigned and truncated to $clog2(ARCH_COUNT) bits; copy_ctr never exceeds ARCH_COUNT/COPY_W-1.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, all counters 0, latches 0. Every output is 0, including drain_timeout_dbg and recover_count_dbg.
  - Asserting reset mid-sequence aborts the sequence immediately, and no redirect is issued.
- With mispredict sampled at edge T and defaults (8 groups, fu_busy=0):
  - FLUSH in cycle T+1.
  - RESTORE in T+2..T+9, with freelist_restore at T+9.
  - DRAIN at T+10.
  - REDIRECT at T+11.
  - IDLE at T+12, when stall_o drops.
- A new mispredict is accepted in the first IDLE cycle, T+12.
- Worst case: DRAIN lasts DRAIN_MAX cycles, so REDIRECT falls at T+10+DRAIN_MAX.
- All pulse outputs are exactly one cycle wide. None of them are asserted in IDLE.

## Test plan
- Basic recovery: mispredict=1 with target 0x1000 and idx 5, fu_busy=0. Required response:
  - flush_o with flush_idx_o=5 at T+1.
  - map_copy_base 0,4,…,28 over T+2..T+9.
  - freelist_restore at T+9.
  - redirect_pc=0x1000 at T+11.
  - stall_o high T+1..T+11.
  - recover_count_dbg=1.
- Drain wait: fu_busy=1 for 3 DRAIN cycles, then 0. The required response is REDIRECT at T+14 and drain_timeout_dbg=0.
- Drain timeout: fu_busy held at 1. The required response is REDIRECT at T+25 and drain_timeout_dbg=1.
- Ignored pulse: a second mispredict with target 0x2000 at T+4. The required response is redirect_pc=0x1000, one redirect only, and count=1.
- Mid-sequence reset: reset=0 at T+5. All outputs go to 0 immediately. After release, no redirect occurs, and a fresh mispredict runs the full sequence.
- Back-to-back: a second mispredict at T+12. The required response is FLUSH at T+13 and recover_count_dbg=2 after its REDIRECT.

Source files
------------

// File: rtl/mispredict_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: flush, restore rename map,
// rebuild freelist, drain in-flight FUs, then redirect fetch.
module mispredict_recovery_ctrl #(
    parameter int N          = 4,
    parameter int ARCH_COUNT = 32,
    parameter int COPY_W     = 4,
    parameter int DRAIN_MAX  = 15,
    parameter int ROB_IDX_W  = 6,
    parameter int ADDR_W     = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          mispredict,
    input  logic [ROB_IDX_W-1:0]          rob_mispred_idx,
    input  logic [ADDR_W-1:0]             redirect_target,
    input  logic                          fu_busy,
    output logic                          flush_o,
    output logic [ROB_IDX_W-1:0]          flush_idx_o,
    output logic                          map_copy_en,
    output logic [$clog2(ARCH_COUNT)-1:0] map_copy_base,
    output logic                          freelist_restore,
    output logic                          stall_o,
    output logic                          redirect_valid,
    output logic [ADDR_W-1:0]             redirect_pc,
    output logic                          drain_timeout_dbg,
    output logic [15:0]                   recover_count_dbg
);

    localparam int GROUPS = ARCH_COUNT / COPY_W;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int BW     = $clog2(ARCH_COUNT);
    localparam int DW     = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

    localparam logic [CW-1:0] LAST_GRP  = CW'(GROUPS - 1);
    localparam logic [DW-1:0] DRAIN_END = DW'(DRAIN_MAX - 1);

    if ((ARCH_COUNT % COPY_W) != 0) begin : g_copy_chk
        $error("ARCH_COUNT must be a multiple of COPY_W");
    end
    if ($clog2(N + 1) > 16) begin : g_cnt_chk
        $error("recover_count_dbg too narrow for retire width");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        RESTORE  = 3'd2,
        DRAIN    = 3'd3,
        REDIRECT = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [CW-1:0]         copy_ctr;
    logic [DW-1:0]         drain_ctr;
    logic [ROB_IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0]     pc_q;
    logic                  last_grp;
    logic                  drain_expire;
    logic                  accept;

    assign last_grp     = (copy_ctr == LAST_GRP);
    assign drain_expire = (drain_ctr == DRAIN_END);
    assign accept       = (state == IDLE) && mispredict;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and outputs, decoded from registered state only
    always_comb begin
        state_nx         = state;
        flush_o          = 1'b0;
        flush_idx_o      = '0;
        map_copy_en      = 1'b0;
        map_copy_base    = '0;
        freelist_restore = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        stall_o          = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (mispredict) state_nx = FLUSH;
            end
            FLUSH: begin
                flush_o     = 1'b1;
                flush_idx_o = idx_q;
                state_nx    = RESTORE;
            end
            RESTORE: begin
                map_copy_en   = 1'b1;
                map_copy_base = BW'(copy_ctr) * BW'(COPY_W);
                if (last_grp) begin
                    freelist_restore = 1'b1;
                    state_nx         = DRAIN;
                end
            end
            DRAIN: begin
                if (!fu_busy || drain_expire) state_nx = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = pc_q;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture the branch index and target only when a recovery starts
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            pc_q  <= '0;
        end else if (accept) begin
            idx_q <= rob_mispred_idx;
            pc_q  <= redirect_target;
        end
    end

    // Map-copy group counter, holds at the last group
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            copy_ctr <= '0;
        end else if (state == FLUSH) begin
            copy_ctr <= '0;
        end else if (state == RESTORE && !last_grp) begin
            copy_ctr <= copy_ctr + 1'b1;
        end
    end

    // Drain cycle counter, cleared on the way into DRAIN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drain_ctr <= '0;
        end else if (state == RESTORE) begin
            drain_ctr <= '0;
        end else if (state == DRAIN && fu_busy && !drain_expire) begin
            drain_ctr <= drain_ctr + 1'b1;
        end
    end

    // Debug: sticky drain timeout and completed-recovery count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drain_timeout_dbg <= 1'b0;
            recover_count_dbg <= '0;
        end else begin
            if (state == DRAIN && fu_busy && drain_expire) begin
                drain_timeout_dbg <= 1'b1;
            end
            if (state == REDIRECT) begin
                recover_count_dbg <= recover_count_dbg + 16'd1;
            end
        end
    end

endmodule
